// File: rtl/series_seq_pkg.sv
// Shared definitions for the series evaluation controller.
//   state_t       : controller states
//   CNT_W_DEFAULT : default width of the term counter, n_terms and term_idx
package series_seq_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL,
    S_WAIT,
    S_ACC,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/term_counter.sv
// Term index counter for the series controller.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clear    : synchronous clear to 0 (takes priority over enable)
//   enable   : advance to the next term
//   n_terms  : latched number of terms
//   idx      : current term index
//   last     : idx is the final term (idx == n_terms-1)
module term_counter #(
  parameter int CNT_W = series_seq_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] n_terms,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  // The compare is one bit wider so that n_terms = 0 never matches a
  // wrapped idx+1.
  assign last = ({1'b0, idx} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, n_terms};

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (enable && !last) begin
      // Holding at the last term keeps the counter from wrapping.
      idx <= idx + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/series_seq_controller.sv
// Control FSM for a power-series evaluator (sum of coefficient * x^k terms).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin an evaluation (honoured only in IDLE)
//   abort               : cancel a running evaluation, back to IDLE
//   n_terms             : number of terms, latched at start
//   mode_vld, alt_sign  : explicit sign mode at start, else ALT_DEFAULT
//   mul_done            : datapath multiply complete (pulse)
//   lt_comp             : current term magnitude below epsilon
//   xld, rinit, tinit   : load x, clear result, preset term to 1
//   mul_go              : multiply launch pulse
//   tld, rld            : load term register, load result register
//   add_sub             : 0 = r+t, 1 = r-t
//   term_idx            : coefficient ROM address
//   ready, done         : idle indicator, completion pulse
module series_seq_controller
  import series_seq_pkg::*;
#(
  parameter int   CNT_W       = CNT_W_DEFAULT,
  parameter logic ALT_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             mode_vld,
  input  logic             alt_sign,
  input  logic             mul_done,
  input  logic             lt_comp,
  output logic             xld,
  output logic             rinit,
  output logic             tinit,
  output logic             mul_go,
  output logic             tld,
  output logic             rld,
  output logic             add_sub,
  output logic [CNT_W-1:0] term_idx,
  output logic             ready,
  output logic             done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic             alt_lat;
  logic             last;
  logic             cnt_clear, cnt_enable;

  term_counter #(.CNT_W(CNT_W)) u_term_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .n_terms (n_lat),
    .idx     (term_idx),
    .last    (last)
  );

  // NOTE: state_nxt gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_INIT;
        S_INIT:  state_nxt = (n_lat == '0) ? S_DONE : S_MUL;
        S_MUL:   state_nxt = S_WAIT;
        S_WAIT:  if (mul_done) state_nxt = S_ACC;
        S_ACC:   state_nxt = S_CHECK;
        S_CHECK: state_nxt = (lt_comp || last) ? S_DONE : S_MUL;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign cnt_clear  = (state == S_INIT);
  assign cnt_enable = (state == S_CHECK) && (state_nxt == S_MUL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      n_lat   <= '0;
      alt_lat <= ALT_DEFAULT;
    end else begin
      state <= state_nxt;
      // Operands are captured once so later input changes cannot disturb
      // an evaluation in flight.
      if (state == S_IDLE && start) begin
        n_lat   <= n_terms;
        alt_lat <= mode_vld ? alt_sign : ALT_DEFAULT;
      end
    end
  end

  // Moore outputs decoded from the state register; tld alone follows
  // mul_done so the term register captures the product in the same cycle.
  assign ready   = (state == S_IDLE);
  assign xld     = (state == S_INIT);
  assign rinit   = (state == S_INIT);
  assign tinit   = (state == S_INIT);
  assign mul_go  = (state == S_MUL);
  assign tld     = (state == S_WAIT) && mul_done;
  assign rld     = (state == S_ACC);
  assign add_sub = (state == S_ACC) && alt_lat && term_idx[0];
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_series_seq_controller.sv
// Directed bench for series_seq_controller: cycle-accurate latency, sign
// pattern, early stop, abort, asynchronous reset and busy-start cases.
module tb_series_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, mode_vld, alt_sign, mul_done, lt_comp;
  logic [3:0] n_terms;

  // Outputs of the default instance (a) and the ALT_DEFAULT=0 instance (b).
  logic       xld_a, rinit_a, tinit_a, mul_go_a, tld_a, rld_a, add_sub_a, ready_a, done_a;
  logic       xld_b, rinit_b, tinit_b, mul_go_b, tld_b, rld_b, add_sub_b, ready_b, done_b;
  logic [3:0] idx_a, idx_b;

  // Observed signals, taken from the instance chosen by sel_b.
  logic       sel_b;
  logic       o_mul_go, o_rld, o_add_sub, o_ready, o_done;
  logic [3:0] o_idx;

  int errors = 0;
  int checks = 0;

  // Per-run observations.
  int          done_cyc, done_cnt, go_cnt, rld_cnt, idx_done;
  logic [15:0] as_bits;

  always #5 clk = ~clk;

  series_seq_controller dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_terms(n_terms),
    .mode_vld(mode_vld), .alt_sign(alt_sign), .mul_done(mul_done), .lt_comp(lt_comp),
    .xld(xld_a), .rinit(rinit_a), .tinit(tinit_a), .mul_go(mul_go_a), .tld(tld_a),
    .rld(rld_a), .add_sub(add_sub_a), .term_idx(idx_a), .ready(ready_a), .done(done_a)
  );

  series_seq_controller #(.ALT_DEFAULT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_terms(n_terms),
    .mode_vld(mode_vld), .alt_sign(alt_sign), .mul_done(mul_done), .lt_comp(lt_comp),
    .xld(xld_b), .rinit(rinit_b), .tinit(tinit_b), .mul_go(mul_go_b), .tld(tld_b),
    .rld(rld_b), .add_sub(add_sub_b), .term_idx(idx_b), .ready(ready_b), .done(done_b)
  );

  always_comb begin
    o_mul_go  = sel_b ? mul_go_b  : mul_go_a;
    o_rld     = sel_b ? rld_b     : rld_a;
    o_add_sub = sel_b ? add_sub_b : add_sub_a;
    o_ready   = sel_b ? ready_b   : ready_a;
    o_done    = sel_b ? done_b    : done_a;
    o_idx     = sel_b ? idx_b     : idx_a;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One evaluation. Start is sampled at edge 0; cycle c is the cycle after
  // edge c-1. The bench acts as the multiplier (mul_done lat cycles after
  // mul_go) and raises lt_comp once stop_at results have been accumulated.
  // After the start, n_terms and mode are scrambled to show they are latched.
  task automatic run_seq(input logic [3:0] n, input logic mv, input logic alt,
                         input int lat, input int stop_at, input int busy_cyc,
                         input int window);
    int go_cyc;
    go_cyc   = -1000;
    done_cyc = -1;
    done_cnt = 0;
    go_cnt   = 0;
    rld_cnt  = 0;
    idx_done = -1;
    as_bits  = '0;
    @(posedge clk); #1;
    start = 1'b1; n_terms = n; mode_vld = mv; alt_sign = alt;
    @(posedge clk);  // edge 0
    for (int c = 1; c <= window; c++) begin
      #1;
      start    = (c == busy_cyc);
      n_terms  = ~n;
      mode_vld = 1'b1;
      alt_sign = ~alt;
      mul_done = (c == go_cyc + lat);
      lt_comp  = (stop_at != 0) && (rld_cnt >= stop_at);
      @(negedge clk);
      if (o_mul_go) begin go_cnt++; go_cyc = c; end
      if (o_rld) begin as_bits[rld_cnt] = o_add_sub; rld_cnt++; end
      if (o_done) begin
        if (done_cnt == 0) begin done_cyc = c; idx_done = int'(o_idx); end
        done_cnt++;
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0; mul_done = 1'b0; lt_comp = 1'b0;
  endtask

  task automatic expect_run(input string tag, input int e_done, input int e_go,
                            input int e_rld, input int e_as, input int e_idx);
    check({tag, " done_cycle"}, done_cyc, e_done);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " mul_go_pulses"}, go_cnt, e_go);
    check({tag, " rld_pulses"}, rld_cnt, e_rld);
    check({tag, " add_sub_bits"}, int'(as_bits), e_as);
    check({tag, " idx_at_done"}, idx_done, e_idx);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; n_terms = '0; mode_vld = 1'b0;
    alt_sign = 1'b0; mul_done = 1'b0; lt_comp = 1'b0; sel_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", int'(ready_a), 1);
    check("rst outputs", int'({xld_a, rinit_a, tinit_a, mul_go_a, tld_a, rld_a, add_sub_a, done_a}), 0);
    check("rst term_idx", int'(idx_a), 0);
    rst = 1'b1;

    // Three alternating terms, L=2: signs +,-,+ ; done at 2+3*5 = 17.
    run_seq(4'd3, 1'b1, 1'b1, 2, 0, 0, 30);
    expect_run("alt3", 17, 3, 3, 'b010, 2);

    // Early stop on lt_comp in the second CHECK: done at 2+2*5 = 12.
    run_seq(4'd4, 1'b1, 1'b1, 2, 2, 0, 30);
    expect_run("early", 12, 2, 2, 'b10, 1);

    // Zero terms: INIT then DONE.
    run_seq(4'd0, 1'b1, 1'b1, 2, 0, 0, 10);
    expect_run("zero", 2, 0, 0, 0, 0);

    // mode_vld=0 uses ALT_DEFAULT=1 (alt_sign ignored), L=1: done 2+3*4 = 14.
    run_seq(4'd3, 1'b0, 1'b0, 1, 0, 0, 25);
    expect_run("dflt1", 14, 3, 3, 'b010, 2);

    // Explicit non-alternating mode: all additions.
    run_seq(4'd2, 1'b1, 1'b0, 1, 0, 0, 20);
    expect_run("noalt", 10, 2, 2, 0, 1);

    // ALT_DEFAULT=0 instance, mode_vld=0: all additions.
    sel_b = 1'b1;
    run_seq(4'd2, 1'b0, 1'b1, 1, 0, 0, 20);
    expect_run("dflt0", 10, 2, 2, 0, 1);
    sel_b = 1'b0;

    // start pulsed during WAIT is ignored; L=3: done at 2+2*6 = 14.
    run_seq(4'd2, 1'b1, 1'b1, 3, 0, 3, 30);
    expect_run("busy", 14, 2, 2, 'b10, 1);

    // Maximum term count, no wrap: done at 2+15*4 = 62.
    run_seq(4'd15, 1'b1, 1'b1, 1, 0, 0, 80);
    expect_run("max", 62, 15, 15, 'h2AAA, 14);

    // Abort in WAIT.
    @(posedge clk); #1;
    start = 1'b1; n_terms = 4'd3; mode_vld = 1'b1; alt_sign = 1'b1;
    @(posedge clk); #1 start = 1'b0;           // cycle 1 INIT
    @(posedge clk); #1;                         // cycle 2 MUL
    @(posedge clk); #1 abort = 1'b1;            // cycle 3 WAIT
    @(negedge clk);
    check("abort busy", int'(ready_a), 0);
    @(posedge clk); #1 abort = 1'b0;            // cycle 4
    check("abort ready", int'(ready_a), 1);
    check("abort mul_go", int'(mul_go_a), 0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("abort no_done", done_cnt, 0);
    run_seq(4'd1, 1'b1, 1'b1, 1, 0, 0, 15);
    expect_run("post_abort", 6, 1, 1, 0, 0);

    // Asynchronous reset in ACC.
    @(posedge clk); #1;
    start = 1'b1; n_terms = 4'd3; mode_vld = 1'b1; alt_sign = 1'b0;
    @(posedge clk); #1 start = 1'b0;           // cycle 1 INIT
    @(posedge clk); #1;                         // cycle 2 MUL
    @(posedge clk); #1;                         // cycle 3 WAIT
    @(posedge clk); #1 mul_done = 1'b1;         // cycle 4 WAIT, product ready
    @(posedge clk); #1 mul_done = 1'b0;         // cycle 5 ACC
    @(negedge clk);
    check("pre_rst rld", int'(rld_a), 1);
    #1 rst = 1'b0;
    #1;
    check("midrst ready", int'(ready_a), 1);
    check("midrst outputs", int'({xld_a, rinit_a, tinit_a, mul_go_a, tld_a, rld_a, add_sub_a, done_a}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    // Latched mode must be back at ALT_DEFAULT=1 after reset.
    run_seq(4'd2, 1'b0, 1'b0, 1, 0, 0, 20);
    expect_run("post_rst", 10, 2, 2, 'b10, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
